// File: rtl/trigger_event_recorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trigger_event_recorder: timestamps L1A/ALCT/TMB/LCT activity into a FIFO  |
// | Optional macro: TREC_OVF_MARKER_EN (flag first record after a drop)       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module trigger_event_recorder #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [15:0] OVF_SAT    = 16'hFFFF,
  parameter logic [31:0] TS_INIT    = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  l1a,
  input  logic                  alct_dav,
  input  logic                  tmb_dav,
  input  logic [7:0]            lct,
  output logic [47:0]           rec_data,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic [15:0]           ovf_cnt
);

  localparam int unsigned          c_DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  c_FULL    = c_DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]  c_CNT_ONE = 1;
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = 1;

  logic [31:0]            ts_q;
  logic                   cap_hit_q;
  logic [47:0]            cap_rec_q;
  logic [47:0]            mem_q [c_DEPTH];
  logic [DEPTH_LOG2-1:0]  wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0]  rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]    count_q, count_d;
  logic [15:0]            ovf_q, ovf_d;
  logic [47:0]            rec_data_q, rec_data_d;
  logic                   rec_valid_q;

  logic                   w_hit;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_push_ok;
  logic                   w_drop;
  logic [47:0]            w_wr_rec;

`ifdef TREC_OVF_MARKER_EN
  logic                   mark_q, mark_d;
`endif

  assign w_hit = l1a | alct_dav | tmb_dav | (lct != 8'h00);

  // A full FIFO still accepts the push when the head leaves on the same edge.
  assign w_pop     = rec_valid_q & rec_ready;
  assign w_full    = (count_q == c_FULL);
  assign w_push_ok = cap_hit_q & (~w_full | w_pop);
  assign w_drop    = cap_hit_q & w_full & ~w_pop;

  always_comb begin
    w_wr_rec = cap_rec_q;
`ifdef TREC_OVF_MARKER_EN
    w_wr_rec[12] = mark_q;
`endif
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (w_push_ok) begin
      wptr_d = wptr_q + c_PTR_ONE;
    end
    if (w_pop) begin
      rptr_d = rptr_q + c_PTR_ONE;
    end
    case ({w_push_ok, w_pop})
      2'b10:   count_d = count_q + c_CNT_ONE;
      2'b01:   count_d = count_q - c_CNT_ONE;
      default: count_d = count_q;
    endcase
    if (w_drop && (ovf_q != OVF_SAT)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  // Next head: the record being written when no older entry survives the pop.
  always_comb begin
    rec_data_d = rec_data_q;
    if (count_d != '0) begin
      if (count_q == {{DEPTH_LOG2{1'b0}}, w_pop}) begin
        rec_data_d = w_wr_rec;
      end else begin
        rec_data_d = mem_q[rptr_d];
      end
    end
  end

`ifdef TREC_OVF_MARKER_EN
  always_comb begin
    mark_d = mark_q;
    if (w_drop) begin
      mark_d = 1'b1;
    end else if (w_push_ok) begin
      mark_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mark_q <= 1'b0;
    end else if (clr) begin
      mark_q <= 1'b0;
    end else begin
      mark_q <= mark_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts_q      <= TS_INIT;
      cap_hit_q <= 1'b0;
      cap_rec_q <= '0;
    end else if (clr) begin
      ts_q      <= TS_INIT;
      cap_hit_q <= 1'b0;
      cap_rec_q <= '0;
    end else if (en) begin
      ts_q      <= ts_q + 32'd1;
      cap_hit_q <= w_hit;
      cap_rec_q <= {ts_q, l1a, alct_dav, tmb_dav, 5'b0_0000, lct};
    end else begin
      cap_hit_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ovf_q       <= '0;
      rec_data_q  <= '0;
      rec_valid_q <= 1'b0;
    end else if (clr) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ovf_q       <= '0;
      rec_data_q  <= '0;
      rec_valid_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      rec_data_q  <= rec_data_d;
      rec_valid_q <= (count_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !clr) begin
      mem_q[wptr_q] <= w_wr_rec;
    end
  end

  assign rec_data   = rec_data_q;
  assign rec_valid  = rec_valid_q;
  assign fifo_count = count_q;
  assign ovf_cnt    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_trigger_event_recorder.sv
`default_nettype none
// Randomized and directed checks of trigger_event_recorder against a queue model.
module tb_trigger_event_recorder;

  localparam int DL2   = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, en, clr, l1a, alct_dav, tmb_dav, rec_ready;
  logic [7:0]  lct;
  logic [47:0] rec_data;
  logic        rec_valid;
  logic [DL2:0] fifo_count;
  logic [15:0] ovf_cnt;

  logic        wr_rstn, wr_en, wr_l1a, wr_ready;
  logic [47:0] wr_data;
  logic        wr_valid;
  logic [DL2:0] wr_count;
  logic [15:0] wr_ovf;

  trigger_event_recorder #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .l1a(l1a), .alct_dav(alct_dav),
    .tmb_dav(tmb_dav), .lct(lct), .rec_data(rec_data), .rec_valid(rec_valid),
    .rec_ready(rec_ready), .fifo_count(fifo_count), .ovf_cnt(ovf_cnt)
  );

  trigger_event_recorder #(.DEPTH_LOG2(DL2), .TS_INIT(32'hFFFF_FFFE)) u_wrap (
    .clk(clk), .rstn(wr_rstn), .en(wr_en), .clr(1'b0), .l1a(wr_l1a), .alct_dav(1'b0),
    .tmb_dav(1'b0), .lct(8'h00), .rec_data(wr_data), .rec_valid(wr_valid),
    .rec_ready(wr_ready), .fifo_count(wr_count), .ovf_cnt(wr_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of records plus one pending captured event.
  logic [31:0] m_ts;
  bit          m_pend;
  logic [47:0] m_pend_rec;
  logic [47:0] m_q[$];
  int          m_ovf;
  bit          m_mark;

  function automatic void model_reset();
    m_ts = 0; m_pend = 0; m_pend_rec = '0; m_q.delete(); m_ovf = 0; m_mark = 0;
  endfunction

  function automatic void model_edge();
    logic [47:0] rec;
    if (!rstn || clr) begin
      model_reset();
      return;
    end
    if (m_q.size() > 0 && rec_ready) void'(m_q.pop_front());
    if (m_pend) begin
      if (m_q.size() < DEPTH) begin
        rec = m_pend_rec;
`ifdef TREC_OVF_MARKER_EN
        rec[12] = m_mark;
`endif
        m_mark = 0;
        m_q.push_back(rec);
      end else begin
        if (m_ovf < 65535) m_ovf++;
        m_mark = 1;
      end
    end
    m_pend = en && (l1a || alct_dav || tmb_dav || lct != 8'h00);
    if (en) begin
      m_pend_rec = {m_ts, l1a, alct_dav, tmb_dav, 5'b0, lct};
      m_ts = m_ts + 32'd1;
    end
  endfunction

  task automatic compare_all(input string tag);
    check_val({tag, "_count"}, 48'(fifo_count), 48'(m_q.size()));
    check_val({tag, "_ovf"},   48'(ovf_cnt),    48'(m_ovf));
    check_val({tag, "_valid"}, 48'(rec_valid),  48'(m_q.size() > 0));
    if (m_q.size() > 0) check_val({tag, "_data"}, rec_data, m_q[0]);
  endtask

  task automatic set_in(input logic e, input logic c, input logic l, input logic a,
                        input logic t, input logic [7:0] lc, input logic r);
    en = e; clr = c; l1a = l; alct_dav = a; tmb_dav = t; lct = lc; rec_ready = r;
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  int bias;

  initial begin
    rstn = 0; wr_rstn = 0; wr_en = 0; wr_l1a = 0; wr_ready = 0;
    set_in(0, 0, 0, 0, 0, 8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_val("rst_valid", 48'(rec_valid), 48'd0);
    check_val("rst_data",  rec_data, 48'd0);
    check_val("rst_count", 48'(fifo_count), 48'd0);
    check_val("rst_ovf",   48'(ovf_cnt), 48'd0);
    rstn = 1; wr_rstn = 1;

    // Timestamp wrap on the preloaded instance
    wr_en = 1; wr_l1a = 1;
    repeat (3) cycle("idle");
    wr_l1a = 0;
    repeat (2) cycle("idle");
    check_val("wrap_count", 48'(wr_count), 48'd3);
    check_val("wrap_r0", wr_data, {32'hFFFF_FFFE, 16'h8000});
    wr_ready = 1;
    cycle("idle");
    check_val("wrap_r1", wr_data, {32'hFFFF_FFFF, 16'h8000});
    cycle("idle");
    check_val("wrap_r2", wr_data, {32'h0000_0000, 16'h8000});
    cycle("idle");
    check_val("wrap_empty", 48'(wr_valid), 48'd0);

    // Single event at ts 5
    set_in(1, 0, 0, 0, 0, 8'h00, 0);
    repeat (5) cycle("t1_idle");
    set_in(1, 0, 1, 0, 0, 8'h03, 0);
    cycle("t1_cap");
    check_val("t1_not_yet_valid", 48'(rec_valid), 48'd0);
    set_in(1, 0, 0, 0, 0, 8'h00, 0);
    cycle("t1_wr");
    check_val("t1_valid", 48'(rec_valid), 48'd1);
    check_val("t1_data", rec_data, 48'h0000_0005_8003);
    set_in(1, 0, 0, 0, 0, 8'h00, 1);
    repeat (2) cycle("t1_drain");

    // Overflow with 20 back-to-back events
    set_in(1, 0, 0, 0, 1, 8'h00, 0);
    repeat (20) cycle("t2_fill");
    set_in(1, 0, 0, 0, 0, 8'h00, 0);
    cycle("t2_last");
    check_val("t2_count", 48'(fifo_count), 48'd16);
    check_val("t2_ovf", 48'(ovf_cnt), 48'd4);

    // Full: push and pop on the same edge
    set_in(1, 0, 0, 0, 1, 8'h00, 0);
    cycle("t3_cap");
    set_in(1, 0, 0, 0, 0, 8'h00, 1);
    cycle("t3_pp");
    check_val("t3_count", 48'(fifo_count), 48'd16);
    check_val("t3_ovf", 48'(ovf_cnt), 48'd4);
    repeat (18) cycle("t3_drain");

    // Disabled capture, then clear mid-stream
    set_in(0, 0, 0, 1, 0, 8'h00, 0);
    repeat (10) cycle("t5_dis");
    check_val("t5_dis_count", 48'(fifo_count), 48'd0);
    set_in(1, 0, 0, 1, 0, 8'h00, 0);
    repeat (3) cycle("t5_hits");
    set_in(1, 1, 0, 1, 0, 8'h00, 0);
    cycle("t5_clr");
    check_val("t5_clr_count", 48'(fifo_count), 48'd0);
    check_val("t5_clr_ovf", 48'(ovf_cnt), 48'd0);
    set_in(1, 0, 0, 0, 0, 8'h00, 0);
    repeat (3) cycle("t5_post");

    // Randomized traffic, with one asynchronous reset in the middle
    bias = 50;
    for (int i = 0; i < 900; i++) begin
      if (i % 100 == 0) bias = ($urandom % 3 == 0) ? 5 : (($urandom % 2 == 0) ? 50 : 95);
      if (i == 450) begin
        rstn = 0;
        model_reset();
        #1;
        check_val("async_rst_valid", 48'(rec_valid), 48'd0);
        check_val("async_rst_count", 48'(fifo_count), 48'd0);
        check_val("async_rst_ovf", 48'(ovf_cnt), 48'd0);
        cycle("rst_hold");
        rstn = 1;
      end
      set_in(($urandom % 8) != 0, ($urandom % 97) == 0, ($urandom % 6) == 0,
             ($urandom % 8) == 0, ($urandom % 5) == 0,
             (($urandom % 4) == 0) ? 8'($urandom) : 8'h00,
             ($urandom % 100) < bias);
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
